// File: rtl/stage2_seq_pkg.sv
// Shared types, constants and stage lookup for the stage-2 job sequencer.
// Datapath geometry (NSTAGE, STEP_W) is fixed here and used by every file of the block.
package stage2_seq_pkg;

  localparam int NSTAGE = 7;
  localparam int STEP_W = 8;
  // Prefix sums are wide enough that even NSTAGE maximal lengths cannot wrap.
  localparam int ACC_W  = STEP_W + 4;

  localparam logic [2:0] STAGE_FIN  = 3'd7;
  localparam logic [2:0] MODE_STAGE = 3'd1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} stage2_state_e;

  typedef logic [NSTAGE-1:0][STEP_W-1:0] stage_vec_t;

  // Smallest non-empty stage whose boundary still covers step; STAGE_FIN once past the end.
  function automatic logic [2:0] next_stage(input logic [STEP_W:0] step,
                                            input stage_vec_t      bounds,
                                            input stage_vec_t      lens);
    logic [2:0] stage;
    stage = STAGE_FIN;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (lens[k] != '0 && step <= {1'b0, bounds[k]}) stage = 3'(k);
    end
    return stage;
  endfunction

endpackage

// File: rtl/stage2_bound_acc.sv
// Combinational prefix sum of per-stage lengths: boundary[k] = sum(len[0..k]) - 1,
// plus an overflow flag when the job total exceeds 2^STEP_W steps.
module stage2_bound_acc
  import stage2_seq_pkg::*;
(
  input  stage_vec_t lens_i,
  output stage_vec_t bounds_o,
  output logic       ovf_o
);

  logic [ACC_W-1:0] sum;

  // NOTE: every variable written here gets a value before any branch or loop, so no latch can form.
  always_comb begin
    sum      = '0;
    bounds_o = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      sum         = sum + ACC_W'(lens_i[k]);
      bounds_o[k] = STEP_W'(sum - ACC_W'(1));
    end
    ovf_o = sum > ACC_W'(1 << STEP_W);
  end

endmodule

// File: rtl/stage2_seq_ctrl.sv
// Stage-2 job sequencer: captures stage lengths, steps through stages under a
// valid/ready handshake and pulses done. Define STAGE2_SEQ_PERF_EN for perf counters.
module stage2_seq_ctrl
  import stage2_seq_pkg::*;
(
  input  logic                     CLK_i,
  input  logic                     RST_ni,
  input  logic                     start_i,
  input  logic [NSTAGE*STEP_W-1:0] stage_len_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic                     stall_o,
  output logic [2:0]               stage_o,
  output logic [STEP_W-1:0]        step_o,
  output logic [NSTAGE*STEP_W-1:0] stage_boundary_o,
  output logic                     mode_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
`ifdef STAGE2_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_run_cnt_o
`endif
);

  stage2_state_e     state_q, state_d;
  stage_vec_t        len_q, len_d;
  stage_vec_t        bnd_q, bnd_d;
  stage_vec_t        acc_bnd;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        stage_q, stage_d;
  logic              err_q, err_d;
  logic              acc_ovf;
  logic              fire;
  logic              accept;
  logic [STEP_W:0]   step_inc;
  logic [2:0]        load_stage;
  logic [2:0]        run_stage;

  stage2_bound_acc u_bound_acc (
    .lens_i   (len_q),
    .bounds_o (acc_bnd),
    .ovf_o    (acc_ovf)
  );

  assign fire       = (state_q == RUN) && in_valid_i && out_ready_i;
  assign accept     = (state_q == IDLE) && start_i;
  // One extra bit so a job of exactly 2^STEP_W steps still sees its end after step wraps.
  assign step_inc   = {1'b0, step_q} + (STEP_W + 1)'(1);
  assign load_stage = next_stage('0, acc_bnd, len_q);
  assign run_stage  = next_stage(step_inc, bnd_q, len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bnd_d   = bnd_q;
    step_d  = step_q;
    stage_d = stage_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = stage_len_i;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (acc_ovf) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          bnd_d   = acc_bnd;
          step_d  = '0;
          stage_d = load_stage;
          state_d = (load_stage == STAGE_FIN) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          step_d  = step_inc[STEP_W-1:0];
          stage_d = run_stage;
          if (run_stage == STAGE_FIN) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      bnd_q   <= '0;
      step_q  <= '0;
      stage_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bnd_q   <= bnd_d;
      step_q  <= step_d;
      stage_q <= stage_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o       = fire;
  assign out_valid_o      = fire;
  assign stall_o          = !fire;
  assign stage_o          = stage_q;
  assign step_o           = step_q;
  assign stage_boundary_o = bnd_q;
  assign mode_o           = (stage_q != MODE_STAGE);
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign err_o            = err_q;

`ifdef STAGE2_SEQ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_run_q;

  always_ff @(posedge CLK_i) begin
    if (!RST_ni || accept) begin
      perf_stall_q <= '0;
      perf_run_q   <= '0;
    end else if (state_q == RUN) begin
      if (perf_run_q != '1)            perf_run_q   <= perf_run_q + 32'd1;
      if (!fire && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_run_cnt_o   = perf_run_q;
`endif

endmodule
